controle_multiciclo: RTL and testbench

//  Multicycle RV32I control FSM that sequences the register bank, ALU and data memory.

---
 rtl/controle_multiciclo_pkg.sv | 49 ++++
 rtl/controle_multiciclo_if.sv | 31 +++
 rtl/controle_multiciclo_sincroniza_passo.sv | 25 ++
 rtl/controle_multiciclo.sv | 125 ++++++++++++
 tb/tb_controle_multiciclo.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32I control: state codes, opcodes, ALU op codes.
package controle_multiciclo_pkg;

  // State encoding is visible on estado; the register bank keys its writes off 0110/0111.
  typedef enum logic [3:0] {
    StFetch   = 4'b0000,
    StDecode  = 4'b0001,
    StExecR   = 4'b0010,
    StExecI   = 4'b0011,
    StMemAddr = 4'b0100,
    StMemWr   = 4'b0101,
    StWbAlu   = 4'b0110,
    StWbMem   = 4'b0111,
    StBranch  = 4'b1000,
    StHalt    = 4'b1001
  } estado_e;

  // Opcode class captured when DECODE is left.
  typedef enum logic [2:0] {
    ClsNone,
    ClsR,
    ClsI,
    ClsLw,
    ClsSw,
    ClsBeq
  } classe_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic classe_e classifica(input logic [6:0] op);
    case (op)
      OP_R:    return ClsR;
      OP_I:    return ClsI;
      OP_LW:   return ClsLw;
      OP_SW:   return ClsSw;
      OP_BEQ:  return ClsBeq;
      default: return ClsNone;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control-to-datapath bundle: opcode/zero in, state and control strobes out.
interface controle_multiciclo_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [6:0]       opcode;
  logic             zero;
  logic [3:0]       estado;
  logic             irwrite;
  logic             pcwrite;
  logic             pcsrc;
  logic             regiwrite;
  logic             memtoreg;
  logic             memread;
  logic             memwrite;
  logic             alusrc;
  logic [1:0]       aluop;
  logic             erro;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero,
    output estado, irwrite, pcwrite, pcsrc, regiwrite, memtoreg, memread, memwrite,
    output alusrc, aluop, erro, instr_count
  );

  modport slave (
    output opcode, zero,
    input  estado, irwrite, pcwrite, pcsrc, regiwrite, memtoreg, memread, memwrite,
    input  alusrc, aluop, erro, instr_count
  );
endinterface

// File: rtl/controle_multiciclo_sincroniza_passo.sv
// Step-button synchroniser: two flops against metastability, then a one-clk rising-edge pulse.
module sincroniza_passo (
  input  logic clk,
  input  logic rst,
  input  logic passo,
  output logic passo_pulso
);
  logic sync1_q, sync2_q, edge_q;

  // Synchroniser chain plus the previous-sample register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= passo;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // High between the 2nd and 3rd edge after a press, so the FSM moves on the 3rd.
  assign passo_pulso = sync2_q & ~edge_q;
endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  modo,
  input  logic                  passo,
  controle_multiciclo_if.master bus
);
  estado_e          estado_q, estado_d;
  classe_e          classe_q, classe_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             erro_q, erro_d;
  logic             passo_pulso;
  logic             avanca;
  logic             strobe_en;

  sincroniza_passo u_sincroniza_passo (
    .clk         (clk),
    .rst         (rst),
    .passo       (passo),
    .passo_pulso (passo_pulso)
  );

  assign avanca    = modo | passo_pulso;
  // Write strobes only fire on a cycle that actually advances, and never during reset.
  assign strobe_en = avanca & ~rst;

  // State, class, counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= StFetch;
      classe_q <= ClsNone;
      count_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      classe_q <= classe_d;
      count_q  <= count_d;
      erro_q   <= erro_d;
    end
  end

  // Next-state logic; everything holds unless avanca.
  always_comb begin
    estado_d = estado_q;
    classe_d = classe_q;
    count_d  = count_q;
    erro_d   = erro_q;
    if (avanca) begin
      case (estado_q)
        StFetch:  estado_d = StDecode;
        StDecode: begin
          classe_d = classifica(bus.opcode);
          case (classe_d)
            ClsR:         estado_d = StExecR;
            ClsI:         estado_d = StExecI;
            ClsLw, ClsSw: estado_d = StMemAddr;
            ClsBeq:       estado_d = StBranch;
            default: begin
              estado_d = StHalt;
              erro_d   = 1'b1;
            end
          endcase
        end
        StExecR, StExecI: estado_d = StWbAlu;
        StMemAddr:        estado_d = (classe_q == ClsSw) ? StMemWr : StWbMem;
        StMemWr, StWbAlu, StWbMem, StBranch: begin
          estado_d = StFetch;
          count_d  = count_q + CNT_W'(1);
        end
        StHalt:  estado_d = StHalt;
        default: estado_d = StFetch;
      endcase
    end
  end

  // Moore output decode; write strobes additionally gated by strobe_en.
  always_comb begin
    bus.irwrite   = 1'b0;
    bus.pcwrite   = 1'b0;
    bus.pcsrc     = 1'b0;
    bus.regiwrite = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.alusrc    = 1'b0;
    bus.aluop     = ALUOP_ADD;
    case (estado_q)
      StFetch: begin
        bus.irwrite = strobe_en;
        bus.pcwrite = strobe_en;
      end
      StExecR: bus.aluop = ALUOP_FUNCT;
      StExecI: begin
        bus.alusrc = 1'b1;
        bus.aluop  = ALUOP_FUNCT;
      end
      StMemAddr: begin
        bus.alusrc  = 1'b1;
        bus.memread = (classe_q == ClsLw);
      end
      StMemWr: bus.memwrite = strobe_en;
      StWbAlu: bus.regiwrite = strobe_en;
      StWbMem: begin
        bus.regiwrite = strobe_en;
        bus.memtoreg  = 1'b1;
        bus.memread   = 1'b1;
      end
      StBranch: begin
        bus.aluop   = ALUOP_SUB;
        bus.pcsrc   = 1'b1;
        bus.pcwrite = strobe_en & bus.zero;
      end
      default: ;
    endcase
  end

  assign bus.estado      = estado_q;
  assign bus.erro        = erro_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed steps plus random instruction streams vs. a path model.
module tb_controle_multiciclo;
  import controle_multiciclo_pkg::*;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst, modo, passo;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt      = 0;
  int   path[$];
  logic [6:0] ops [5] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

  controle_multiciclo_if #(.CNT_W(CW)) bus ();

  controle_multiciclo #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .modo  (modo),
    .passo (passo),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {irwrite, pcwrite, pcsrc, regiwrite, memtoreg, memread, memwrite, alusrc, aluop}
  function automatic logic [9:0] strobes();
    return {bus.irwrite, bus.pcwrite, bus.pcsrc, bus.regiwrite, bus.memtoreg, bus.memread,
            bus.memwrite, bus.alusrc, bus.aluop};
  endfunction

  // Control table from the state list: which signals each state asserts.
  function automatic logic [9:0] exp_strobes(input int st, input bit adv, input bit z,
                                             input bit lw);
    bit ir = 0, pcw = 0, pcs = 0, rw = 0, m2r = 0, mr = 0, mw = 0, as = 0;
    logic [1:0] op = 2'b00;
    case (st)
      0: begin ir = adv; pcw = adv; end
      2: op = 2'b10;
      3: begin as = 1; op = 2'b10; end
      4: begin as = 1; mr = lw; end
      5: mw = adv;
      6: rw = adv;
      7: begin rw = adv; m2r = 1; mr = 1; end
      8: begin op = 2'b01; pcs = 1; pcw = adv & z; end
      default: ;
    endcase
    return {ir, pcw, pcs, rw, m2r, mr, mw, as, op};
  endfunction

  // Expected sequence of states an instruction walks through, from FETCH.
  task automatic build_path(input logic [6:0] op);
    path.delete();
    case (op)
      OP_R:    path = '{0, 1, 2, 6};
      OP_I:    path = '{0, 1, 3, 6};
      OP_LW:   path = '{0, 1, 4, 7};
      OP_SW:   path = '{0, 1, 4, 5};
      OP_BEQ:  path = '{0, 1, 8};
      default: path = '{0, 1};
    endcase
  endtask

  // Called just after a negedge with the DUT in FETCH and modo=1; returns in FETCH.
  // zmode: 0/1 fixed zero, 2 random.
  task automatic do_instr(input logic [6:0] op, input int zmode, input string tag);
    bit lw = (op == OP_LW);
    build_path(op);
    for (int i = 0; i < path.size(); i++) begin
      // After DECODE the opcode is scrambled: the class must come from the register.
      bus.opcode = (i >= 2) ? 7'($urandom) : op;
      bus.zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check({tag, " estado"}, 32'(bus.estado), path[i]);
      check({tag, " strobes"}, 32'(strobes()), 32'(exp_strobes(path[i], 1'b1, bus.zero, lw)));
      if (i == 0) check({tag, " count"}, 32'(bus.instr_count), cnt % 16);
      @(negedge clk);
    end
    cnt++;
  endtask

  initial begin
    int hits;
    rst = 1'b1; modo = 1'b1; passo = 1'b0;
    bus.opcode = '0; bus.zero = 1'b0;
    #1;
    check("reset estado", 32'(bus.estado), 0);
    check("reset strobes", 32'(strobes()), 0);
    check("reset erro", 32'(bus.erro), 0);
    check("reset count", 32'(bus.instr_count), 0);
    @(negedge clk);
    check("reset held strobes", 32'(strobes()), 0);
    rst = 1'b0;

    do_instr(OP_R, 2, "add");
    do_instr(OP_LW, 2, "lw");
    do_instr(OP_SW, 2, "sw");
    do_instr(OP_BEQ, 1, "beq z1");
    do_instr(OP_BEQ, 0, "beq z0");
    do_instr(OP_I, 2, "addi");
    check("count after six", 32'(bus.instr_count), cnt % 16);

    // Single step with passo held 20 clks in WB_ALU.
    bus.opcode = OP_R;
    repeat (3) @(negedge clk);
    modo = 1'b0; passo = 1'b0;
    #1;
    check("step wb estado", 32'(bus.estado), 6);
    check("step wb idle regiwrite", 32'(bus.regiwrite), 0);
    passo = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.regiwrite) hits++;
      check("step estado", 32'(bus.estado), (i < 2) ? 6 : 0);
    end
    check("step regiwrite hits", hits, 1);
    cnt++;
    check("step count", 32'(bus.instr_count), cnt % 16);
    passo = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("step no advance", 32'(bus.estado), 0);
    check("step fetch idle strobes", 32'(strobes()), 0);
    modo = 1'b1;

    // Random stream, long enough to wrap the 4-bit counter.
    for (int k = 0; k < 40; k++) begin
      do_instr(ops[$urandom_range(0, 4)], 2, "rand");
    end
    check("rand count", 32'(bus.instr_count), cnt % 16);

    // Reset in EXEC_R.
    bus.opcode = OP_R;
    repeat (2) @(negedge clk);
    #1;
    check("pre-rst estado", 32'(bus.estado), 2);
    rst = 1'b1;
    #1;
    check("rst async estado", 32'(bus.estado), 0);
    check("rst async strobes", 32'(strobes()), 0);
    check("rst async count", 32'(bus.instr_count), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    #1;
    check("post-rst fetch strobes", 32'(strobes()), 32'(exp_strobes(0, 1'b1, 1'b0, 1'b0)));
    @(negedge clk);
    #1;
    check("post-rst decode", 32'(bus.estado), 1);
    repeat (3) @(negedge clk);
    #1;
    check("post-rst back in fetch", 32'(bus.estado), 0);
    cnt = 1;
    check("post-rst count", 32'(bus.instr_count), cnt);

    // Illegal opcode: HALT, sticky erro, held 50 clks.
    bus.opcode = 7'b1111111;
    @(negedge clk);
    #1;
    check("illegal decode", 32'(bus.estado), 1);
    check("illegal erro pre", 32'(bus.erro), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.opcode = 7'($urandom);
      #1;
      check("halt estado", 32'(bus.estado), 9);
      check("halt erro", 32'(bus.erro), 1);
      check("halt strobes", 32'(strobes()), 0);
    end
    check("halt count", 32'(bus.instr_count), cnt);
    rst = 1'b1;
    #1;
    check("halt rst estado", 32'(bus.estado), 0);
    check("halt rst erro", 32'(bus.erro), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    do_instr(OP_SW, 2, "sw after halt");
    check("final count", 32'(bus.instr_count), cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
